modexp_controller: RTL

MODEXP_CONTROLLER -- requirements
Module: modexp_controller

---
 rtl/modexp_controller.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/modexp_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : modexp_controller                                          |
// | Brief   : Left-to-right binary modular exponentiation sequencer that |
// |           drives an external modular multiplier, one op in flight.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module modexp_controller #(
  parameter int EXP_W   = 256,
  parameter int MUL_LAT = 25,
  parameter int TMO_CYC = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [255:0]       base,
  input  logic [EXP_W-1:0]   exponent,
  output logic               busy,
  output logic               done,
  output logic [255:0]       result,
  output logic               err_timeout,
  output logic               mul_err,
  output logic               mul_in_valid,
  output logic [255:0]       mul_x,
  output logic [255:0]       mul_y,
  input  logic               mul_out_valid,
  input  logic [255:0]       mul_q
);

  // Timeout is forced above the nominal multiplier latency so a healthy
  // multiplier can never be aborted by a mis-set parameter.
  localparam int c_TMO   = (TMO_CYC > MUL_LAT) ? TMO_CYC : MUL_LAT + 1;
  localparam int c_CNT_W = $clog2(c_TMO + 1);
  localparam int c_IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_TOP  = c_IDX_W'(EXP_W - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_TMO - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    SQ_ISSUE  = 3'd2,
    SQ_WAIT   = 3'd3,
    MUL_ISSUE = 3'd4,
    MUL_WAIT  = 3'd5,
    FINISH    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [c_IDX_W-1:0]   idx_q, idx_d;
  logic [EXP_W-1:0]     exp_q, exp_d;
  logic [255:0]         base_q, base_d;
  logic [255:0]         acc_q, acc_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [255:0]         result_q, result_d;
  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;
  logic                 merr_q, merr_d;
  logic                 mvalid_q, mvalid_d;
  logic [255:0]         mx_q, mx_d;
  logic [255:0]         my_q, my_d;
  logic                 bit_w;
  logic                 in_wait_w;

  assign bit_w     = exp_q[idx_q];
  assign in_wait_w = (state_q == SQ_WAIT) || (state_q == MUL_WAIT);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    exp_d    = exp_q;
    base_d   = base_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    merr_d   = merr_q;
    mvalid_d = 1'b0;
    mx_d     = mx_q;
    my_d     = my_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base;
          exp_d   = exponent;
          idx_d   = c_IDX_TOP;
          merr_d  = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bit_w) begin
          acc_d = base_q;
          if (idx_q == '0) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q - c_IDX_W'(1);
            state_d = SQ_ISSUE;
          end
        end else if (idx_q == '0) begin
          acc_d   = 256'd1;
          state_d = FINISH;
        end else begin
          idx_d = idx_q - c_IDX_W'(1);
        end
      end
      SQ_ISSUE: begin
        cnt_d   = '0;
        state_d = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (mul_out_valid) begin
          acc_d = mul_q;
          cnt_d = '0;
          if (bit_w) begin
            state_d = MUL_ISSUE;
          end else if (idx_q == '0) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q - c_IDX_W'(1);
            state_d = SQ_ISSUE;
          end
        end else if (cnt_q == c_CNT_LAST) begin
          cnt_d    = '0;
          result_d = '0;
          done_d   = 1'b1;
          tmo_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      MUL_ISSUE: begin
        cnt_d   = '0;
        state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_out_valid) begin
          acc_d = mul_q;
          cnt_d = '0;
          if (idx_q == '0) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q - c_IDX_W'(1);
            state_d = SQ_ISSUE;
          end
        end else if (cnt_q == c_CNT_LAST) begin
          cnt_d    = '0;
          result_d = '0;
          done_d   = 1'b1;
          tmo_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end
      FINISH: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A response nobody asked for is flagged; it wins over a same-cycle start.
    if (mul_out_valid && !in_wait_w) begin
      merr_d = 1'b1;
    end

    // Operands are loaded on entry to an issue state so they are stable
    // for the whole issue cycle and then simply hold.
    if (state_d == SQ_ISSUE) begin
      mvalid_d = 1'b1;
      mx_d     = acc_d;
      my_d     = acc_d;
    end else if (state_d == MUL_ISSUE) begin
      mvalid_d = 1'b1;
      mx_d     = acc_d;
      my_d     = base_q;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      exp_q    <= '0;
      base_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      merr_q   <= 1'b0;
      mvalid_q <= 1'b0;
      mx_q     <= '0;
      my_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      exp_q    <= exp_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      merr_q   <= merr_d;
      mvalid_q <= mvalid_d;
      mx_q     <= mx_d;
      my_q     <= my_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign result       = result_q;
  assign err_timeout  = tmo_q;
  assign mul_err      = merr_q;
  assign mul_in_valid = mvalid_q;
  assign mul_x        = mx_q;
  assign mul_y        = my_q;

endmodule
`default_nettype wire
